counter_mod_param: RTL and testbench
====================================

Name: counter_mod_param

Overview:
- Parametrised successor to the team's 4-bit multi-mode counter: same mode set plus generic width, programmable step and modulus.
- Adds cascade input/output so counters can be chained into wider or multi-digit counters.
- Drop-in DUV for the existing test/checker bench structure. The checker model is updated to match.

Parameters:
- WIDTH, 4: counter width in bits.
- STEP, 3: increment applied in mode 2'b00. Legal range 1 <= STEP < MODULUS.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1: rising-edge clock, single clock domain.
- reset  input  1: reset is synchronous and active-low.
- enable  input  1: global enable. Gates counting and loading.
- cin  input  1: cascade enable. Counting advances only if enable && cin. Tie to 1 when unused.
- mode  input  2: 00 up by STEP, 01 down by 1, 10 up by 1, 11 load D.
- D  input  WIDTH: parallel load value.
- Q  output  WIDTH: registered count.
- rco  output  1: registered wrap pulse.
- load  output  1: registered load-done flag.
- tc  output  1: combinational terminal-count, used as cin of the next stage.

Behaviour:
- Sampling: all state updates on posedge clk. Q, rco and load are registers.
- Reset: reset==0 at a clock edge forces Q=0, rco=0, load=0 on that edge. Reset overrides every other input, including mid-count and during a load.
- Enable low: when enable==0, Q holds, rco=0, load=0.
- Count gate: when enable==1 and cin==0 in modes 00, 01 or 10, Q holds and rco=0.
- Arithmetic: computed in WIDTH+1 bits, then reduced modulo MODULUS. The result is always in 0..MODULUS-1.
- Mode 00: Q_next = (Q+STEP) mod MODULUS. rco=1 on that edge if Q+STEP >= MODULUS, else 0.
- Mode 01: Q_next = (Q==0) ? MODULUS-1 : Q-1. rco=1 on that edge if Q==0.
- Mode 10: Q_next = (Q+1) mod MODULUS. rco=1 on that edge if Q==MODULUS-1.
- Mode 11: Q_next = D, or MODULUS-1 if D >= MODULUS (clamp).
  - load=1 and rco=0 for that cycle.
  - Ignores cin; requires enable only.
- load in other modes: load=0 in every mode other than 11.
- rco/load timing: both are single-cycle flags aligned with the Q value they describe, i.e. visible the cycle after the triggering edge. Consecutive wraps produce rco high on consecutive cycles.
- tc: tc = enable && cin && (the current mode would wrap on the next edge); 0 in mode 11.
  - Purely combinational from Q, mode, enable and cin. No registered path.
- Mode change: may occur on any cycle and takes effect on the next edge. No internal state beyond Q, rco and load.
- Reset release: Q=0 on the first post-reset edge unless a load or count applies on that same edge.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- Defined: counting saturates instead of wrapping.
  - Mode 00/10: Q_next = min(Q+step, MODULUS-1).
  - Mode 01: Q_next = max(Q-1, 0).
  - rco=1 on any count edge where clamping occurred, i.e. the requested value was out of range, including repeated attempts at the bound.
  - tc reflects the same clamp condition.
- Undefined: wrap-around behaviour as specified in Behaviour. No saturation logic is synthesised.

Test Plan:
1. Reset and enable: WIDTH=4, MODULUS=10, STEP=3. Load Q=5, then hold reset=0 for 2 cycles in mode 10 with enable=1 -> Q=0, rco=0, load=0 after the first reset edge. Release reset, then drop enable for 3 cycles -> Q stays 0, flags 0.
2. Mode 00 wrap: load D=8, then one mode 00 edge -> Q=1, rco=1 for one cycle. Next edge -> Q=4, rco=0. tc=1 while Q=8, 0 at Q=4.
3. Mode 01 wrap: load D=0 (load=1 next cycle), then mode 01 -> Q=9, rco=1. Next edges -> Q=8, then 7, with rco=0.
4. Load clamp and cin gating:
   - Load D=12 -> Q=9, load=1.
   - Load with cin=0 still loads.
   - Mode 10 with cin=0 -> Q holds 9, rco=0.
   - cin=1 -> Q=0, rco=1.
5. Cascade: two instances, WIDTH=4, MODULUS=10, STEP=1, mode 10; low.tc drives high.cin. Count 0..99 -> high increments exactly when low wraps 9->0. After 100 edges, {high,low}=0/0 and high.rco pulses once.
6. With COUNTER_SAT_EN defined:
   - Load 8, mode 00 -> Q=9, rco=1. Again -> Q=9, rco=1.
   - Mode 01 from 0 -> Q=0, rco=1.
   - Mode 10 from 5 -> Q=6, rco=0.

Source files
------------

// File: rtl/counter_mod_param.sv
// Parametrised modulo counter: up-by-STEP, down, up-by-1 and load modes, with cascade cin/tc.
// Define COUNTER_SAT_EN to make counting saturate at the range bounds instead of wrapping.
module counter_mod_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned STEP    = 3,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load,
    output logic             tc
);

    localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   StepExt = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MaxQ    = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] d_clamp;
    logic [WIDTH:0]   sum_step;
    logic             ovf;

    // One extra bit so Q+STEP cannot overflow before the modulus compare.
    assign sum_step = {1'b0, q_q} + StepExt;
    assign d_clamp  = ({1'b0, D} >= ModExt) ? MaxQ : D;

    // ovf is the wrap (or clamp) condition of the selected count mode; it drives both rco and tc.
    always_comb begin
        cnt_next = q_q;
        ovf      = 1'b0;
        case (mode)
            2'b00: begin
                ovf = (sum_step >= ModExt);
`ifdef COUNTER_SAT_EN
                cnt_next = ovf ? MaxQ : sum_step[WIDTH-1:0];
`else
                cnt_next = ovf ? WIDTH'(sum_step - ModExt) : sum_step[WIDTH-1:0];
`endif
            end
            2'b01: begin
                ovf = (q_q == '0);
`ifdef COUNTER_SAT_EN
                cnt_next = ovf ? '0 : q_q - WIDTH'(1);
`else
                cnt_next = ovf ? MaxQ : q_q - WIDTH'(1);
`endif
            end
            2'b10: begin
                ovf = (q_q == MaxQ);
`ifdef COUNTER_SAT_EN
                cnt_next = ovf ? MaxQ : q_q + WIDTH'(1);
`else
                cnt_next = ovf ? '0 : q_q + WIDTH'(1);
`endif
            end
            default: begin
                cnt_next = q_q;
                ovf      = 1'b0;
            end
        endcase
    end

    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            if (mode == 2'b11) begin
                q_d    = d_clamp;
                load_d = 1'b1;
            end else if (cin) begin
                q_d   = cnt_next;
                rco_d = ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign Q    = q_q;
    assign rco  = rco_q;
    assign load = load_q;
    assign tc   = enable & cin & ovf;

endmodule

// File: tb/tb_counter_mod_param.sv
// Directed bench for counter_mod_param: a MODULUS=10/STEP=3 instance plus a two-digit cascade.
module tb_counter_mod_param;

    logic       clk;
    logic       reset, enable, cin;
    logic [1:0] mode;
    logic [3:0] D;
    logic [3:0] Q;
    logic       rco, load, tc;

    logic       c_reset, c_enable;
    logic [1:0] c_mode;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_load, hi_load, lo_tc, hi_tc;

    int n_cmp;
    int n_err;

    counter_mod_param #(.WIDTH(4), .STEP(3), .MODULUS(10)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode), .D(D),
        .Q(Q), .rco(rco), .load(load), .tc(tc)
    );

    counter_mod_param #(.WIDTH(4), .STEP(1), .MODULUS(10)) u_lo (
        .clk(clk), .reset(c_reset), .enable(c_enable), .cin(1'b1), .mode(c_mode), .D(4'd0),
        .Q(lo_q), .rco(lo_rco), .load(lo_load), .tc(lo_tc)
    );

    counter_mod_param #(.WIDTH(4), .STEP(1), .MODULUS(10)) u_hi (
        .clk(clk), .reset(c_reset), .enable(c_enable), .cin(lo_tc), .mode(c_mode), .D(4'd0),
        .Q(hi_q), .rco(hi_rco), .load(hi_load), .tc(hi_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] eq, input logic erco,
                               input logic eload);
        check_eq({tag, ".Q"}, 32'(Q), 32'(eq));
        check_eq({tag, ".rco"}, 32'(rco), 32'(erco));
        check_eq({tag, ".load"}, 32'(load), 32'(eload));
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        cin      = 1'b1;
        mode     = 2'b00;
        D        = 4'd0;
        c_reset  = 1'b0;
        c_enable = 1'b0;
        c_mode   = 2'b10;
        tick();
        tick();
        check_state("rst", 4'd0, 1'b0, 1'b0);

        // Reset and enable
        reset = 1'b1; enable = 1'b1; mode = 2'b11; D = 4'd5;
        tick();
        check_state("ld5", 4'd5, 1'b0, 1'b1);
        reset = 1'b0; mode = 2'b10;
        tick();
        check_state("rst1", 4'd0, 1'b0, 1'b0);
        tick();
        check_state("rst2", 4'd0, 1'b0, 1'b0);
        reset = 1'b1; enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("en_lo", 4'd0, 1'b0, 1'b0);
        end
        enable = 1'b1;

`ifndef COUNTER_SAT_EN
        // Mode 00 wrap
        mode = 2'b11; D = 4'd8;
        tick();
        check_state("ld8", 4'd8, 1'b0, 1'b1);
        mode = 2'b00;
        #1 check_eq("tc_q8", 32'(tc), 32'd1);
        tick();
        check_state("up3_wrap", 4'd1, 1'b1, 1'b0);
        tick();
        check_state("up3", 4'd4, 1'b0, 1'b0);
        check_eq("tc_q4", 32'(tc), 32'd0);

        // Mode 01 wrap
        mode = 2'b11; D = 4'd0;
        #1 check_eq("tc_m11", 32'(tc), 32'd0);
        tick();
        check_state("ld0", 4'd0, 1'b0, 1'b1);
        mode = 2'b01;
        #1 check_eq("tc_dn0", 32'(tc), 32'd1);
        tick();
        check_state("dn_wrap", 4'd9, 1'b1, 1'b0);
        tick();
        check_state("dn8", 4'd8, 1'b0, 1'b0);
        tick();
        check_state("dn7", 4'd7, 1'b0, 1'b0);

        // Consecutive wraps: 7+3 -> 0, then down from 0 -> 9
        mode = 2'b00;
        tick();
        check_state("cw1", 4'd0, 1'b1, 1'b0);
        mode = 2'b01;
        tick();
        check_state("cw2", 4'd9, 1'b1, 1'b0);
`else
        mode = 2'b11; D = 4'd8;
        tick();
        check_state("s_ld8", 4'd8, 1'b0, 1'b1);
        mode = 2'b00;
        tick();
        check_state("s_up1", 4'd9, 1'b1, 1'b0);
        check_eq("s_tc9", 32'(tc), 32'd1);
        tick();
        check_state("s_up2", 4'd9, 1'b1, 1'b0);
        mode = 2'b11; D = 4'd0;
        tick();
        check_state("s_ld0", 4'd0, 1'b0, 1'b1);
        mode = 2'b01;
        tick();
        check_state("s_dn0", 4'd0, 1'b1, 1'b0);
        mode = 2'b11; D = 4'd5;
        tick();
        check_state("s_ld5", 4'd5, 1'b0, 1'b1);
        mode = 2'b10;
        tick();
        check_state("s_up6", 4'd6, 1'b0, 1'b0);
`endif

        // Load clamp and cin gating
        mode = 2'b11; D = 4'd12;
        tick();
        check_state("ld_clamp", 4'd9, 1'b0, 1'b1);
        cin = 1'b0; D = 4'd3;
        tick();
        check_state("ld_cin0", 4'd3, 1'b0, 1'b1);
        D = 4'd9;
        tick();
        check_state("ld9_cin0", 4'd9, 1'b0, 1'b1);
        mode = 2'b10;
        #1 check_eq("tc_cin0", 32'(tc), 32'd0);
        tick();
        check_state("hold_cin0", 4'd9, 1'b0, 1'b0);
        cin = 1'b1;
        #1 check_eq("tc_cin1", 32'(tc), 32'd1);
        tick();
`ifndef COUNTER_SAT_EN
        check_state("up1_wrap", 4'd0, 1'b1, 1'b0);
`else
        check_state("up1_sat", 4'd9, 1'b1, 1'b0);
`endif
        enable = 1'b0;
        tick();
        check_state("en_off", Q, 1'b0, 1'b0);

        // Reset overrides a load on the same edge
        enable = 1'b1; mode = 2'b11; D = 4'd7; reset = 1'b0;
        tick();
        check_state("rst_ld", 4'd0, 1'b0, 1'b0);
        reset = 1'b1; enable = 1'b0;

`ifndef COUNTER_SAT_EN
        // Cascade: 100 edges of a two-digit decimal counter
        c_reset = 1'b1; c_enable = 1'b1; c_mode = 2'b10;
        for (int k = 1; k <= 100; k++) begin
            tick();
            check_eq("cas_lo", 32'(lo_q), 32'(k % 10));
            check_eq("cas_hi", 32'(hi_q), 32'((k / 10) % 10));
            check_eq("cas_lo_rco", 32'(lo_rco), 32'(k % 10 == 0));
            check_eq("cas_hi_rco", 32'(hi_rco), 32'(k == 100));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
